// File: rtl/window_pkg.sv
// Shared types and constants for the 5x5 window loader.
// The FSM state encoding lives here so the loader and any future observers agree on it.
package window_pkg;

  localparam int WIN_DIM  = 5;
  localparam int WIN_SIZE = WIN_DIM * WIN_DIM;
  localparam int WIN_HALF = WIN_DIM / 2;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    REQ,
    WAIT_DATA,
    SAVE,
    HOLD,
    WAIT_FULL,
    DONE
  } state_t;

  // True once the raster walk has reached the bottom-right tap of the window.
  function automatic logic is_last_tap(input logic [2:0] dy, input logic [2:0] dx);
    return (dy == 3'(WIN_DIM - 1)) && (dx == 3'(WIN_DIM - 1));
  endfunction

endpackage

// File: rtl/window_addr_gen.sv
// Combinational address generator: clamps the window tap to the image and
// linearises it as base + r*width + c, wrapping modulo 2^ADDR_W.
module window_addr_gen
  import window_pkg::*;
#(
  parameter int ADDR_W = 18,
  parameter int DIM_W  = 10
) (
  input  logic [DIM_W-1:0]  row_i,
  input  logic [DIM_W-1:0]  col_i,
  input  logic [DIM_W-1:0]  width_i,
  input  logic [DIM_W-1:0]  height_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic [2:0]        dy_i,
  input  logic [2:0]        dx_i,
  output logic [ADDR_W-1:0] addr_o
);

  localparam int SW = DIM_W + 2;

  logic signed [SW-1:0]  rowS;
  logic signed [SW-1:0]  colS;
  logic signed [SW-1:0]  rowMax;
  logic signed [SW-1:0]  colMax;
  logic signed [SW-1:0]  rowC;
  logic signed [SW-1:0]  colC;
  logic [DIM_W-1:0]      rowU;
  logic [DIM_W-1:0]      colU;
  logic [2*DIM_W-1:0]    prod;

  // Two extra signed bits keep row-2 and row+2 representable, so the
  // low edge clamps to 0 instead of wrapping to a huge unsigned value.
  always_comb begin
    rowS   = $signed({2'b00, row_i}) + $signed(SW'(dy_i)) - $signed(SW'(WIN_HALF));
    colS   = $signed({2'b00, col_i}) + $signed(SW'(dx_i)) - $signed(SW'(WIN_HALF));
    rowMax = $signed({2'b00, height_i}) - $signed(SW'(1));
    colMax = $signed({2'b00, width_i}) - $signed(SW'(1));

    if (rowS < 0)           rowC = '0;
    else if (rowS > rowMax) rowC = rowMax;
    else                    rowC = rowS;

    if (colS < 0)           colC = '0;
    else if (colS > colMax) colC = colMax;
    else                    colC = colS;

    rowU   = DIM_W'(rowC);
    colU   = DIM_W'(colC);
    prod   = (2*DIM_W)'(rowU) * (2*DIM_W)'(width_i);
    addr_o = base_i + ADDR_W'(prod) + ADDR_W'(colU);
  end

endmodule

// File: rtl/window_loader.sv
// Walks a 5x5 neighbourhood in raster order, one outstanding read at a time,
// and streams each returned pixel into the window buffer with a save strobe.
module window_loader
  import window_pkg::*;
#(
  parameter int ADDR_W = 18,
  parameter int DIM_W  = 10
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              i_start,
  input  logic [DIM_W-1:0]  i_row,
  input  logic [DIM_W-1:0]  i_col,
  input  logic [DIM_W-1:0]  i_width,
  input  logic [DIM_W-1:0]  i_height,
  input  logic [ADDR_W-1:0] i_base,
  output logic              o_rd_en,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic              i_rd_valid,
  input  logic [7:0]        i_rd_data,
  output logic [7:0]        o_data,
  output logic              o_save,
  output logic              o_clear,
  input  logic              i_buf_full,
  input  logic              i_abort,
  output logic              o_busy,
  output logic              o_done
);

  state_t            state_q, state_d;
  logic [DIM_W-1:0]  row_q, row_d;
  logic [DIM_W-1:0]  col_q, col_d;
  logic [DIM_W-1:0]  width_q, width_d;
  logic [DIM_W-1:0]  height_q, height_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [2:0]        dy_q, dy_d;
  logic [2:0]        dx_q, dx_d;
  logic [7:0]        data_q, data_d;
  logic              clear_q, clear_d;
  logic [ADDR_W-1:0] tapAddr;

  window_addr_gen #(
    .ADDR_W (ADDR_W),
    .DIM_W  (DIM_W)
  ) u_addr_gen (
    .row_i    (row_q),
    .col_i    (col_q),
    .width_i  (width_q),
    .height_i (height_q),
    .base_i   (base_q),
    .dy_i     (dy_q),
    .dx_i     (dx_q),
    .addr_o   (tapAddr)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= IDLE;
      row_q    <= '0;
      col_q    <= '0;
      width_q  <= '0;
      height_q <= '0;
      base_q   <= '0;
      dy_q     <= '0;
      dx_q     <= '0;
      data_q   <= '0;
      clear_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      col_q    <= col_d;
      width_q  <= width_d;
      height_q <= height_d;
      base_q   <= base_d;
      dy_q     <= dy_d;
      dx_q     <= dx_d;
      data_q   <= data_d;
      clear_q  <= clear_d;
    end
  end

  // The clear strobe is registered so that both the start of a load and an
  // abort produce it in the cycle after the triggering input.
  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    col_d    = col_q;
    width_d  = width_q;
    height_d = height_q;
    base_d   = base_q;
    dy_d     = dy_q;
    dx_d     = dx_q;
    data_d   = data_q;
    clear_d  = 1'b0;

    if (state_q != IDLE && i_abort) begin
      state_d = IDLE;
      clear_d = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (i_start) begin
            state_d  = CLEAR;
            clear_d  = 1'b1;
            row_d    = i_row;
            col_d    = i_col;
            width_d  = i_width;
            height_d = i_height;
            base_d   = i_base;
            dy_d     = '0;
            dx_d     = '0;
          end
        end
        CLEAR:     state_d = REQ;
        REQ:       state_d = WAIT_DATA;
        WAIT_DATA: begin
          if (i_rd_valid) begin
            data_d  = i_rd_data;
            state_d = SAVE;
          end
        end
        SAVE:      state_d = HOLD;
        HOLD: begin
          if (is_last_tap(dy_q, dx_q)) begin
            state_d = WAIT_FULL;
          end else begin
            state_d = REQ;
            if (dx_q == 3'(WIN_DIM - 1)) begin
              dx_d = '0;
              dy_d = dy_q + 3'd1;
            end else begin
              dx_d = dx_q + 3'd1;
            end
          end
        end
        WAIT_FULL: if (i_buf_full) state_d = DONE;
        DONE:      state_d = IDLE;
        default:   state_d = IDLE;
      endcase
    end
  end

  assign o_rd_en   = (state_q == REQ);
  assign o_rd_addr = (state_q == REQ) ? tapAddr : '0;
  assign o_data    = data_q;
  assign o_save    = (state_q == SAVE);
  assign o_clear   = clear_q;
  assign o_busy    = (state_q != IDLE);
  assign o_done    = (state_q == DONE);

endmodule

// File: tb/tb_window_loader.sv
// Randomised scoreboard bench for window_loader: a memory responder with random
// latency, a window-buffer model, and a reference model of the clamped raster walk.
module tb_window_loader;

  localparam int ADDR_W = 18;
  localparam int DIM_W  = 10;

  logic              clk = 1'b0;
  logic              n_rst;
  logic              i_start;
  logic [DIM_W-1:0]  i_row, i_col, i_width, i_height;
  logic [ADDR_W-1:0] i_base;
  logic              o_rd_en;
  logic [ADDR_W-1:0] o_rd_addr;
  logic              i_rd_valid;
  logic [7:0]        i_rd_data;
  logic [7:0]        o_data;
  logic              o_save, o_clear, i_buf_full, i_abort, o_busy, o_done;

  always #5 clk = ~clk;

  window_loader #(.ADDR_W(ADDR_W), .DIM_W(DIM_W)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .i_start    (i_start),
    .i_row      (i_row),
    .i_col      (i_col),
    .i_width    (i_width),
    .i_height   (i_height),
    .i_base     (i_base),
    .o_rd_en    (o_rd_en),
    .o_rd_addr  (o_rd_addr),
    .i_rd_valid (i_rd_valid),
    .i_rd_data  (i_rd_data),
    .o_data     (o_data),
    .o_save     (o_save),
    .o_clear    (o_clear),
    .i_buf_full (i_buf_full),
    .i_abort    (i_abort),
    .o_busy     (o_busy),
    .o_done     (o_done)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [ADDR_W-1:0] expAddrQ[$];
  logic [7:0]        expDataQ[$];
  logic [7:0]        expWin[25];
  logic [7:0]        bufMem[25];
  int bufCnt = 0;
  int readsSeen = 0, savesSeen = 0, clearsSeen = 0, donesSeen = 0;
  bit doneAllowed = 0;
  int latMax = 1;
  int strayReq = 0, strayServed = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: clamp each tap to the image, then base + r*w + c modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] refAddr(input int row, input int col, input int w,
                                                input int h, input int base, input int dy, input int dx);
    int r, c;
    longint a;
    r = row + dy - 2;
    c = col + dx - 2;
    if (r < 0) r = 0;
    if (r > h - 1) r = h - 1;
    if (c < 0) c = 0;
    if (c > w - 1) c = w - 1;
    a = longint'(base) + longint'(r) * longint'(w) + longint'(c);
    return ADDR_W'(a);
  endfunction

  function automatic logic [7:0] pix(input logic [ADDR_W-1:0] a);
    return a[7:0];
  endfunction

  // Memory responder: one outstanding read, random 1..latMax cycle return.
  initial begin : responder
    int lat;
    bit pend;
    logic [ADDR_W-1:0] pAddr;
    pend = 0;
    lat = 0;
    pAddr = '0;
    i_rd_valid = 1'b0;
    i_rd_data = 8'h00;
    forever begin
      @(negedge clk);
      i_rd_valid = 1'b0;
      if (n_rst !== 1'b1) begin
        pend = 0;
      end else begin
        if (pend) begin
          if (lat == 0) begin
            i_rd_valid = 1'b1;
            i_rd_data = pix(pAddr);
            pend = 0;
          end else begin
            lat--;
          end
        end else if (strayReq != strayServed) begin
          i_rd_valid = 1'b1;
          i_rd_data = 8'hEE;
          strayServed++;
        end
        if (o_rd_en === 1'b1) begin
          pend = 1;
          pAddr = o_rd_addr;
          lat = $urandom_range(latMax - 1, 0);
        end
      end
    end
  end

  // Monitor: pops expected reads/saves, checks hold and spacing, models the buffer.
  initial begin : monitor
    int saveGap;
    bit holdCheck;
    logic [7:0] heldData;
    saveGap = 99;
    holdCheck = 0;
    heldData = 8'h00;
    forever begin
      @(negedge clk);
      if (n_rst !== 1'b1) begin
        saveGap = 99;
        holdCheck = 0;
      end else begin
        saveGap++;
        if (holdCheck) begin
          checkOutput("data_hold_after_save", o_data, heldData);
          holdCheck = 0;
        end
        if (o_rd_en === 1'b1) begin
          readsSeen++;
          if (expAddrQ.size() == 0) checkOutput("spurious_rd_en", o_rd_en, 0);
          else checkOutput("rd_addr", o_rd_addr, expAddrQ.pop_front());
        end
        if (o_clear === 1'b1) begin
          clearsSeen++;
          bufCnt = 0;
        end
        if (o_save === 1'b1) begin
          savesSeen++;
          if (expDataQ.size() == 0) checkOutput("spurious_save", o_save, 0);
          else checkOutput("save_data", o_data, expDataQ.pop_front());
          checkOutput("save_gap_ge_2", (saveGap >= 2), 1);
          if (bufCnt < 25) bufMem[bufCnt] = o_data;
          bufCnt++;
          heldData = o_data;
          holdCheck = 1;
          saveGap = 0;
        end
        if (o_done === 1'b1) begin
          donesSeen++;
          if (!doneAllowed) checkOutput("spurious_done", o_done, 0);
        end
      end
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input int row, input int col, input int w, input int h, input int base);
    for (int dy = 0; dy < 5; dy++) begin
      for (int dx = 0; dx < 5; dx++) begin
        logic [ADDR_W-1:0] a;
        a = refAddr(row, col, w, h, base, dy, dx);
        expAddrQ.push_back(a);
        expDataQ.push_back(pix(a));
        expWin[dy*5 + dx] = pix(a);
      end
    end
    i_row = DIM_W'(row);
    i_col = DIM_W'(col);
    i_width = DIM_W'(w);
    i_height = DIM_W'(h);
    i_base = ADDR_W'(base);
    i_start = 1'b1;
    tick(1);
    i_start = 1'b0;
  endtask

  task automatic flushExpected();
    expAddrQ.delete();
    expDataQ.delete();
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_busy"}, o_busy, 0);
    checkOutput({tag, "_strobes"}, {o_rd_en, o_save, o_done}, 3'b000);
    checkOutput({tag, "_rd_addr"}, o_rd_addr, 0);
  endtask

  task automatic runWindow(input int row, input int col, input int w, input int h, input int base,
                           input bit pokeStart, input bit abortAtFull);
    int s0, c0, d0, cyc, bad;
    s0 = savesSeen;
    c0 = clearsSeen;
    d0 = donesSeen;
    applyStimulus(row, col, w, h, base);
    cyc = 0;
    while (savesSeen < s0 + 25 && cyc < 3000) begin
      tick(1);
      cyc++;
      if (pokeStart && cyc == 30) begin
        i_row = '0;
        i_col = '0;
        i_base = 18'h2AAAA;
        i_start = 1'b1;
        tick(1);
        i_start = 1'b0;
      end
    end
    checkOutput("saves_per_window", savesSeen - s0, 25);
    checkOutput("clears_per_window", clearsSeen - c0, 1);
    checkOutput("reads_outstanding", expAddrQ.size(), 0);
    tick(1);
    checkOutput("busy_waiting_full", o_busy, 1);
    if (abortAtFull) begin
      i_buf_full = 1'b1;
      i_abort = 1'b1;
      tick(1);
      i_buf_full = 1'b0;
      i_abort = 1'b0;
      checkOutput("abort_beats_full_clear", o_clear, 1);
      checkOutput("abort_beats_full_busy", o_busy, 0);
      tick(3);
      checkOutput("abort_beats_full_no_done", donesSeen - d0, 0);
    end else begin
      tick($urandom_range(3, 0));
      doneAllowed = 1;
      i_buf_full = 1'b1;
      cyc = 0;
      while (donesSeen == d0 && cyc < 10) begin
        tick(1);
        cyc++;
      end
      i_buf_full = 1'b0;
      tick(1);
      doneAllowed = 0;
      checkOutput("done_pulses", donesSeen - d0, 1);
      checkOutput("idle_after_done", o_busy, 0);
    end
    bad = 0;
    for (int k = 0; k < 25; k++) if (bufMem[k] !== expWin[k]) bad++;
    checkOutput("window_contents_bad_entries", bad, 0);
  endtask

  initial begin : watchdog
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int s0, c0, d0, r0, cyc, w, h;
    n_rst = 1'b0;
    i_start = 1'b0;
    i_abort = 1'b0;
    i_buf_full = 1'b0;
    i_row = '0;
    i_col = '0;
    i_width = '0;
    i_height = '0;
    i_base = '0;
    tick(3);
    checkIdleOutputs("reset");
    checkOutput("reset_clear", o_clear, 0);
    checkOutput("reset_data", o_data, 0);
    n_rst = 1'b1;
    tick(2);
    checkOutput("no_clear_on_release", clearsSeen, 0);

    latMax = 1;
    runWindow(8, 8, 16, 16, 0, 0, 0);
    runWindow(0, 0, 16, 16, 0, 0, 0);
    latMax = 7;
    runWindow(11, 19, 20, 12, 18'h01234, 0, 0);
    runWindow(0, 0, 1, 1, 18'h00777, 0, 0);
    runWindow(3, 2, 40, 30, 18'h3FF80, 1, 0);

    // Abort while idle must be ignored.
    c0 = clearsSeen;
    i_abort = 1'b1;
    tick(1);
    i_abort = 1'b0;
    tick(1);
    checkOutput("idle_abort_no_clear", clearsSeen - c0, 0);
    checkIdleOutputs("idle_abort");

    for (int n = 0; n < 5; n++) begin
      w = $urandom_range(64, 1);
      h = $urandom_range(64, 1);
      runWindow($urandom_range(h - 1, 0), $urandom_range(w - 1, 0), w, h,
                int'($urandom_range(262143, 0)), 0, (n == 2));
    end

    // Abort after the tenth save, then a stray return strobe.
    latMax = 3;
    s0 = savesSeen;
    c0 = clearsSeen;
    d0 = donesSeen;
    r0 = readsSeen;
    applyStimulus(5, 6, 16, 16, 18'h00100);
    cyc = 0;
    while (savesSeen < s0 + 10 && cyc < 2000) begin
      tick(1);
      cyc++;
    end
    checkOutput("abort_saves_before", savesSeen - s0, 10);
    i_abort = 1'b1;
    tick(1);
    i_abort = 1'b0;
    checkOutput("abort_clear_pulse", o_clear, 1);
    checkOutput("abort_idle_next", o_busy, 0);
    flushExpected();
    strayReq++;
    tick(10);
    checkOutput("abort_reads_total", readsSeen - r0, 10);
    checkOutput("abort_stray_no_save", savesSeen - s0, 10);
    checkOutput("abort_stray_data_kept", o_data, expWin[9]);
    checkOutput("abort_no_done", donesSeen - d0, 0);
    checkOutput("abort_clears", clearsSeen - c0, 2);
    checkIdleOutputs("after_abort");

    // Reset while waiting for read data, then a fresh load.
    latMax = 7;
    r0 = readsSeen;
    applyStimulus(9, 4, 16, 16, 0);
    cyc = 0;
    while (readsSeen < r0 + 3 && cyc < 1000) begin
      tick(1);
      cyc++;
    end
    checkOutput("reset_test_reads", readsSeen - r0, 3);
    n_rst = 1'b0;
    #1;
    checkIdleOutputs("async_reset");
    checkOutput("async_reset_data", o_data, 0);
    checkOutput("async_reset_clear", o_clear, 0);
    flushExpected();
    tick(2);
    c0 = clearsSeen;
    n_rst = 1'b1;
    tick(3);
    checkOutput("release_no_clear", clearsSeen - c0, 0);
    checkIdleOutputs("release");
    runWindow(8, 8, 16, 16, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
